// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Instruction-fetch stage feeding the opcode decoder and control unit. It owns
// the PC, fetches one instruction at a time from instruction memory, holds it
// in the instruction register while the rest of the core executes it, then
// selects the next PC from the decoder's jump/branch/halt outputs and counts
// retired instructions.
//
// Handshake rules (apply to the request channel and to exec_done):
//   - A fetch request transfers on a rising edge where imem_req_valid and
//     imem_req_ready are both high. While imem_req_valid is high, imem_addr is
//     held stable; imem_req_valid is never withdrawn before the transfer.
//   - The response channel has no back-pressure: imem_resp_valid is a
//     one-cycle strobe taken only while waiting for a response.
//   - exec_done is honoured only while inst_valid is high; the next-PC inputs
//     (is_jal, is_jalr, branch, bcond, is_halted, imm, rs1_data) are sampled on
//     that same edge and ignored at all other times.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   imem_req_*          fetch request channel, imem_addr always equals pc
//   imem_resp_*         fetched word strobe and data
//   inst, opcode        instruction register and its opcode field
//   inst_valid          instruction register holds a word under execution
//   exec_done           downstream has finished the current instruction
//   is_jal, is_jalr     decoder jump indications
//   branch, bcond       decoder branch indication and ALU condition
//   is_halted           decoder ECALL indication
//   imm, rs1_data       immediate and rs1 operand for target computation
//   pc, pc_plus4        current PC and its sequential successor
//   halted, misaligned  core stopped, and whether a bad target stopped it
//   instret             retired-instruction counter (wraps)

module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic [XLEN-1:0] inst,
    output logic [6:0]      opcode,
    output logic            inst_valid,
    input  logic            exec_done,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch,
    input  logic            bcond,
    input  logic            is_halted,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            halted,
    output logic            misaligned,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Clears bit 0 of a jalr target.
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            misaligned_q, misaligned_d;
    logic [31:0]     instret_q, instret_d;
    logic [XLEN-1:0] next_pc;

    // Next-PC select, priority jalr > jal > taken branch > sequential.
    // Arithmetic wraps modulo 2^XLEN.
    always_comb begin
        if (is_jalr) begin
            next_pc = (rs1_data + imm) & JALR_MASK;
        end else if (is_jal) begin
            next_pc = pc_q + imm;
        end else if (branch && bcond) begin
            next_pc = pc_q + imm;
        end else begin
            next_pc = pc_q + XLEN'(4);
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_d         = inst_q;
        misaligned_d   = misaligned_q;
        instret_d      = instret_q;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        halted         = 1'b0;

        case (state_q)
            ST_REQ: begin
                // Any response strobe seen here is stale and ignored.
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_resp_valid) begin
                    inst_d  = imem_resp_data;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                inst_valid = 1'b1;
                if (exec_done) begin
                    // ECALL and a misaligned target both retire the current
                    // instruction but leave pc pointing at it.
                    instret_d = instret_q + 32'd1;
                    if (is_halted) begin
                        state_d = ST_HALT;
                    end else if (next_pc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                        state_d      = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            misaligned_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            misaligned_q <= misaligned_d;
            instret_q    <= instret_d;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + XLEN'(4);
    assign inst       = inst_q;
    assign opcode     = inst_q[6:0];
    assign misaligned = misaligned_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed control-flow cases followed by a
// randomized instruction stream, checked against a behavioural PC model.

module tb_fetch_sequencer;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic        inst_valid;
    logic        exec_done, is_jal, is_jalr, branch, bcond, is_halted;
    logic [31:0] imm, rs1_data;
    logic [31:0] pc, pc_plus4;
    logic        halted, misaligned;
    logic [31:0] instret;

    fetch_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .opcode          (opcode),
        .inst_valid      (inst_valid),
        .exec_done       (exec_done),
        .is_jal          (is_jal),
        .is_jalr         (is_jalr),
        .branch          (branch),
        .bcond           (bcond),
        .is_halted       (is_halted),
        .imm             (imm),
        .rs1_data        (rs1_data),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .halted          (halted),
        .misaligned      (misaligned),
        .instret         (instret)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    int          cyc = 0;
    int          hs_gap = 0;

    // Reference model: architectural PC, retire count and halt status.
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    bit          m_halted;
    bit          m_mis;
    logic [31:0] mem [64];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        exec_done       = 1'b0;
        is_jal          = 1'b0;
        is_jalr         = 1'b0;
        branch          = 1'b0;
        bcond           = 1'b0;
        is_halted       = 1'b0;
        imm             = '0;
        rs1_data        = '0;
    endtask

    // ---------------- monitor ----------------
    // Samples on the falling edge: what it sees is what the next rising edge acts on.
    initial begin : monitor
        logic        prev_req;
        logic [31:0] prev_addr;
        logic        prev_iv;
        logic [31:0] exp_w;
        logic [6:0]  exp_op;
        int          last_hs;
        prev_req  = 1'b0;
        prev_addr = '0;
        prev_iv   = 1'b0;
        last_hs   = -1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_req = 1'b0;
                prev_iv  = 1'b0;
                last_hs  = -1;
            end else begin
                if (prev_req && imem_req_valid)
                    check32("addr_stable", imem_addr, prev_addr);
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
                    end else begin
                        check32("fetch_addr", imem_addr, exp_addr_q.pop_front());
                    end
                    hs_gap  = (last_hs >= 0) ? (cyc - last_hs) : 0;
                    last_hs = cyc;
                end
                if (inst_valid && !prev_iv) begin
                    if (exp_inst_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_inst: got %h expected no instruction", inst);
                    end else begin
                        exp_w  = exp_inst_q.pop_front();
                        exp_op = exp_w[6:0];
                        check32("inst_word", inst, exp_w);
                        check32("opcode", {25'b0, opcode}, {25'b0, exp_op});
                    end
                end
                prev_req  = imem_req_valid;
                prev_addr = imem_addr;
                prev_iv   = inst_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        check32("queue_addr_empty", 32'(exp_addr_q.size()), 32'd0);
        check32("queue_inst_empty", 32'(exp_inst_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_inst_q.delete();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        check1("rst_req_valid", imem_req_valid, 1'b1);
        check32("rst_addr", imem_addr, RESET_PC);
        check32("rst_pc", pc, RESET_PC);
        check32("rst_inst", inst, 32'h0);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check1("rst_halted", halted, 1'b0);
        check1("rst_misaligned", misaligned, 1'b0);
        check32("rst_instret", instret, 32'h0);
        reset     = 1'b0;
        m_pc      = RESET_PC;
        m_instret = '0;
        m_halted  = 1'b0;
        m_mis     = 1'b0;
        step();
        check1("post_rst_req_valid", imem_req_valid, 1'b1);
        check32("post_rst_addr", imem_addr, RESET_PC);
    endtask

    // One full instruction: fetch with optional stalls, response after
    // 'delay' wait cycles, exec_done after 'xdelay' extra execute cycles.
    task automatic do_instr(input bit jal_i, input bit jalr_i, input bit br_i,
                            input bit bc_i, input bit hlt_i,
                            input logic [31:0] imm_i, input logic [31:0] rs1_i,
                            input int stall, input int delay, input int xdelay,
                            input bit spurious, input bit chk_gap);
        logic [31:0] req_addr;
        logic [31:0] nxt;
        int          n;
        exp_addr_q.push_back(m_pc);
        exp_inst_q.push_back(mem_word(m_pc));
        n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        if (!imem_req_valid) begin
            check1("req_timeout", imem_req_valid, 1'b1);
            return;
        end
        imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            imem_resp_valid = spurious;
            imem_resp_data  = 32'hDEAD_BEEF;
            step();
            check1("stall_req_valid", imem_req_valid, 1'b1);
            check1("stall_inst_valid", inst_valid, 1'b0);
        end
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        req_addr        = imem_addr;
        step();
        imem_req_ready = 1'b0;
        if (chk_gap)
            check32("fetch_gap", 32'(hs_gap), 32'd3);
        for (int i = 0; i < delay; i++) begin
            check1("wait_inst_valid", inst_valid, 1'b0);
            check1("wait_req_valid", imem_req_valid, 1'b0);
            step();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(req_addr);
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        for (int i = 0; i < xdelay; i++) begin
            // Decoder outputs toggle freely until exec_done; they must be ignored.
            is_halted = 1'b1;
            is_jal    = 1'b1;
            is_jalr   = 1'($urandom_range(0, 1));
            branch    = 1'b1;
            bcond     = 1'b1;
            imm       = $urandom;
            rs1_data  = $urandom;
            check1("exec_inst_valid", inst_valid, 1'b1);
            check32("exec_pc_hold", pc, m_pc);
            step();
        end
        check1("exec_inst_valid", inst_valid, 1'b1);
        check32("exec_pc", pc, m_pc);
        check32("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
        exec_done = 1'b1;
        is_jal    = jal_i;
        is_jalr   = jalr_i;
        branch    = br_i;
        bcond     = bc_i;
        is_halted = hlt_i;
        imm       = imm_i;
        rs1_data  = rs1_i;
        m_instret = m_instret + 32'd1;
        if (hlt_i) begin
            m_halted = 1'b1;
        end else begin
            if (jalr_i)                  nxt = (rs1_i + imm_i) & 32'hFFFF_FFFE;
            else if (jal_i)              nxt = m_pc + imm_i;
            else if (br_i && bc_i)       nxt = m_pc + imm_i;
            else                         nxt = m_pc + 32'd4;
            if (nxt % 4 != 0) begin
                m_halted = 1'b1;
                m_mis    = 1'b1;
            end else begin
                m_pc = nxt;
            end
        end
        step();
        idle_inputs();
        check32("instret", instret, m_instret);
        check32("next_pc", pc, m_pc);
        check1("halted", halted, m_halted);
        check1("misaligned", misaligned, m_mis);
        check1("post_exec_inst_valid", inst_valid, 1'b0);
        check1("post_exec_req_valid", imem_req_valid, !m_halted);
    endtask

    task automatic seq_instr(input int stall, input int delay, input int xdelay, input bit chk_gap);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, stall, delay, xdelay, 1'b0, chk_gap);
    endtask

    // After a halt every input is ignored and no request is ever raised.
    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_req_ready  = 1'b1;
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            exec_done       = 1'b1;
            is_jal          = 1'($urandom_range(0, 1));
            is_halted       = 1'($urandom_range(0, 1));
            imm             = 32'd4;
            step();
            check1("halt_req_valid", imem_req_valid, 1'b0);
            check1("halt_halted", halted, 1'b1);
            check1("halt_inst_valid", inst_valid, 1'b0);
            check32("halt_pc", pc, m_pc);
            check32("halt_instret", instret, m_instret);
        end
        idle_inputs();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    bit          r_jal, r_jalr, r_br, r_bc, r_hlt;
    logic [31:0] r_imm, r_rs1;

    initial begin
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;

        apply_reset();

        // Sequential run at full speed: fetches 3 cycles apart.
        seq_instr(0, 0, 0, 1'b0);
        seq_instr(0, 0, 0, 1'b1);
        seq_instr(0, 0, 0, 1'b1);
        seq_instr(0, 0, 0, 1'b1);
        check32("seq_pc", pc, 32'd16);
        check32("seq_instret", instret, 32'd4);

        // Control flow.
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 0, 0, 0, 1'b0, 1'b1);
        check32("jal_16_to_8", pc, 32'h8);
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        check32("jal_8_to_0", pc, 32'h0);
        seq_instr(0, 0, 0, 1'b0);
        seq_instr(0, 0, 0, 1'b0);
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'h101, 0, 0, 0, 1'b0, 1'b0);
        check32("jalr_target", pc, 32'h104);
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF04, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        check32("jal_back_to_8", pc, 32'h8);
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        check32("branch_not_taken", pc, 32'd12);
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd16, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        check32("branch_taken", pc, 32'd24);

        // Handshake stall with spurious response during REQ, late exec_done.
        seq_instr(5, 3, 2, 1'b0);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5, 3, 1, 1'b1, 1'b0);
        check32("after_stall_pc", pc, 32'h20);

        // ECALL halt.
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        check32("ecall_pc", pc, 32'h20);
        check1("ecall_halted", halted, 1'b1);
        check1("ecall_not_misaligned", misaligned, 1'b0);
        idle_check(6);

        // Misaligned jal target.
        apply_reset();
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        check1("mis_flag", misaligned, 1'b1);
        check1("mis_halted", halted, 1'b1);
        check32("mis_pc", pc, 32'h0);
        idle_check(4);

        // Asynchronous reset in the middle of a memory wait.
        apply_reset();
        seq_instr(0, 0, 0, 1'b0);
        seq_instr(0, 1, 0, 1'b0);
        exp_addr_q.push_back(m_pc);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check1("async_req_valid", imem_req_valid, 1'b1);
        check32("async_pc", pc, RESET_PC);
        check32("async_instret", instret, 32'h0);
        check1("async_inst_valid", inst_valid, 1'b0);
        apply_reset();
        seq_instr(0, 0, 0, 1'b0);
        check32("restart_pc", pc, RESET_PC + 32'd4);

        // Randomized stream.
        for (int k = 0; k < 80; k++) begin
            if (m_halted) begin
                idle_check(2);
                apply_reset();
            end
            r_hlt  = ($urandom_range(0, 99) < 4);
            r_jal  = ($urandom_range(0, 2) == 0);
            r_jalr = ($urandom_range(0, 3) == 0);
            r_br   = ($urandom_range(0, 2) == 0);
            r_bc   = 1'($urandom_range(0, 1));
            r_imm  = 32'($urandom_range(0, 511)) * 32'd4 - 32'd1024;
            if ($urandom_range(0, 9) == 0) r_imm = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 11) == 0) r_imm = r_imm + 32'($urandom_range(1, 3));
            r_rs1 = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) r_rs1 = r_rs1 | 32'($urandom_range(1, 3));
            do_instr(r_jal, r_jalr, r_br, r_bc, r_hlt, r_imm, r_rs1,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'b0);
        end
        step();
        step();
        check32("final_addr_queue", 32'(exp_addr_q.size()), 32'd0);
        check32("final_inst_queue", 32'(exp_inst_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch stage that sits directly upstream of the opcode decoder and control unit. It owns the PC and issues fetch requests to instruction memory over a valid/ready handshake. It holds the fetched word in an instruction register and presents its opcode field to the decoder. It then consumes the decoder's jump, branch and halt signals to select the next PC, and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, width of PC, address, instruction and data paths

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  fetch address (equals pc)
imem_resp_valid  input  1  fetched word valid
imem_resp_data  input  XLEN  fetched word
inst  output  XLEN  instruction register
opcode  output  7  inst[6:0], drives decoder
inst_valid  output  1  inst held for execution
exec_done  input  1  downstream finished current instruction; next-PC inputs valid this cycle
is_jal  input  1  from decoder
is_jalr  input  1  from decoder
branch  input  1  from decoder
bcond  input  1  branch condition from ALU
is_halted  input  1  from decoder (ECALL)
imm  input  XLEN  sign-extended immediate
rs1_data  input  XLEN  register rs1 value
pc  output  XLEN  current PC
pc_plus4  output  XLEN  pc + 4 (for pc_to_reg writeback)
halted  output  1  core stopped
misaligned  output  1  halt caused by misaligned next PC
instret  output  32  retired-instruction counter

Behaviour:
- Reset (async, active-high) sets:
  - pc = RESET_PC, inst = 0, inst_valid = 0, halted = 0, misaligned = 0, instret = 0, state = REQ.
  - Reset mid-transaction aborts it. Instruction memory shares reset and drops outstanding requests.
- State machine, four states.
- REQ:
  - imem_req_valid = 1, imem_addr = pc.
  - Handshake completes when imem_req_valid && imem_req_ready at a rising edge; then go to WAIT.
  - imem_resp_valid is ignored in REQ.
- WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid: inst <= imem_resp_data, go to EXEC.
  - The earliest response is the cycle after request acceptance.
  - Wait is unbounded; no timeout.
- EXEC:
  - inst_valid = 1; inst and pc are held stable.
  - exec_done may be high on the first EXEC cycle (single-cycle datapath) or any later cycle. Inputs other than exec_done are sampled only on the exec_done cycle.
  - On exec_done with is_halted = 1: go to HALT. pc is unchanged; instret increments (ECALL retires).
  - On exec_done otherwise, next PC priority:
    - is_jalr: (rs1_data + imm) & ~1
    - else is_jal: pc + imm
    - else branch && bcond: pc + imm
    - else: pc + 4
  - All next-PC arithmetic is modulo 2^XLEN; wrap-around is silent.
  - If next PC [1:0] != 0: misaligned <= 1, go to HALT, pc unchanged; instret increments.
  - Else: pc <= next PC, instret += 1, go to REQ.
- HALT:
  - halted = 1, imem_req_valid = 0, inst_valid = 0.
  - Terminal until reset; all inputs ignored.
- Combinational outputs: opcode = inst[6:0]; pc_plus4 = pc + 4.
- instret wraps from 2^32-1 to 0.
- Next-PC select is combinational from registered pc and the inputs. PC update is one edge after exec_done.
- Per instruction with zero memory wait, a fetch takes at least 3 cycles: REQ, WAIT, EXEC.

Test Plan:
- Reset: reset = 1, then release with RESET_PC = 0 → imem_addr = 0, imem_req_valid = 1, instret = 0. Mem returns 32'h00500093 → opcode = 7'h13, inst_valid = 1.
- Sequential run: four ADDI words, exec_done on the first EXEC cycle → pc sequence 0, 4, 8, 12, 16; instret = 4; 3 cycles per instruction with ready = 1 and a 1-cycle response.
- Control flow at pc = 8:
  - jal, imm = -8 → next fetch at 0.
  - jalr, rs1_data = 0x101, imm = 3 → next fetch at 0x104.
  - branch with bcond = 0 → 12; bcond = 1, imm = 16 → 24.
- Handshake stall: imem_req_ready low for 5 cycles, then response after 3 cycles → imem_addr stable throughout, inst_valid asserts only after the response. A spurious imem_resp_valid in REQ is ignored.
- Halt paths:
  - ECALL at pc = 0x20 → halted = 1, pc = 0x20, instret incremented, no further requests.
  - jal with imm = 2 → misaligned = 1, halted = 1.
- Async reset mid-WAIT: reset asserted between edges → outputs clear immediately. After release, the fetch restarts at RESET_PC.
